// File: rtl/lutram_frame_ctrl_pkg.sv
// lutram_frame_ctrl_pkg: shared NPU frame constants and sequencer state encoding
package lutram_frame_ctrl_pkg;
  localparam int BIT_DEPTH = 8;
  localparam int ADDR_WIDTH = 10;
  localparam int DEPTH = 784;
  typedef enum logic [1:0] {LOAD, STREAM, DRAIN} state_t;
endpackage

// File: rtl/lutram_frame_ctrl_out_stage.sv
// frame_out_stage: output register with valid/ready hold; drops valid when drained with no new load
module frame_out_stage #(
  parameter int BIT_DEPTH = 8,
  parameter int PASS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src_valid,
  input  logic [BIT_DEPTH-1:0]  src_data,
  input  logic                  src_last,
  input  logic [PASS_WIDTH-1:0] src_pass,
  input  logic                  out_ready,
  output logic                  can_load,
  output logic                  out_valid,
  output logic [BIT_DEPTH-1:0]  out_data,
  output logic                  out_last,
  output logic [PASS_WIDTH-1:0] out_pass
);
  assign can_load = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_pass  <= '0;
    end else if (src_valid && can_load) begin
      out_valid <= 1'b1;
      out_data  <= src_data;
      out_last  <= src_last;
      out_pass  <= src_pass;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/lutram_frame_ctrl.sv
// lutram_frame_ctrl: loads one frame into the input LUTRAM, then replays it num_passes times
module lutram_frame_ctrl #(
  parameter int BIT_DEPTH  = lutram_frame_ctrl_pkg::BIT_DEPTH,
  parameter int ADDR_WIDTH = lutram_frame_ctrl_pkg::ADDR_WIDTH,
  parameter int DEPTH      = lutram_frame_ctrl_pkg::DEPTH,
  parameter int PASS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [BIT_DEPTH-1:0]  in_data,
  output logic                  in_ready,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [BIT_DEPTH-1:0]  ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [BIT_DEPTH-1:0]  ram_rd_data,
  output logic                  out_valid,
  output logic [BIT_DEPTH-1:0]  out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [PASS_WIDTH-1:0] out_pass,
  output logic                  frame_done
);
  import lutram_frame_ctrl_pkg::*;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] wcnt, rptr;
  logic [PASS_WIDTH-1:0] pcnt, passes;
  logic can_load, ld, wr_last, rd_last, pass_last, done_hs;
  assign in_ready    = state == LOAD;
  assign ram_wr_en   = in_valid && in_ready;
  assign ram_wr_addr = wcnt;
  assign ram_wr_data = in_data;
  assign ram_rd_addr = rptr;
  assign ld          = state == STREAM && can_load;
  assign wr_last     = wcnt == ADDR_WIDTH'(DEPTH - 1);
  assign rd_last     = rptr == ADDR_WIDTH'(DEPTH - 1);
  assign pass_last   = pcnt == passes - PASS_WIDTH'(1);
  assign done_hs     = state == DRAIN && out_valid && out_ready;
  always_comb begin
    state_nxt = state;
    state_nxt = state == LOAD   ? (ram_wr_en && wr_last ? STREAM : LOAD) :
                state == STREAM ? (ld && rd_last && pass_last ? DRAIN : STREAM) :
                                  (done_hs ? LOAD : DRAIN);
  end
  always_ff @(posedge clk) state <= !rst_n ? LOAD : state_nxt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt       <= '0;
      rptr       <= '0;
      pcnt       <= '0;
      passes     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_hs;
      if (ram_wr_en) wcnt <= wr_last ? '0 : wcnt + 1'b1;
      if (ram_wr_en && wr_last) begin
        passes <= num_passes == '0 ? PASS_WIDTH'(1) : num_passes;
        rptr   <= '0;
        pcnt   <= '0;
      end
      // the final pixel of the final pass leaves rptr parked until the next frame
      if (ld && !(rd_last && pass_last)) begin
        rptr <= rd_last ? '0 : rptr + 1'b1;
        if (rd_last) pcnt <= pcnt + 1'b1;
      end
    end
  end
  frame_out_stage #(.BIT_DEPTH(BIT_DEPTH), .PASS_WIDTH(PASS_WIDTH)) u_out (
    .clk(clk),
    .rst_n(rst_n),
    .src_valid(state == STREAM),
    .src_data(ram_rd_data),
    .src_last(rd_last),
    .src_pass(pcnt),
    .out_ready(out_ready),
    .can_load(can_load),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_pass(out_pass)
  );
endmodule

// File: tb/tb_lutram_frame_ctrl.sv
// tb_lutram_frame_ctrl: directed scenarios against a LUTRAM model beside the sequencer
module tb_lutram_frame_ctrl;
  localparam int BD = 8, AW = 10, DEPTH = 784, PW = 8, BIG = 1 << 30;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, ram_wr_en, out_valid, out_last, out_ready = 0, frame_done;
  logic [BD-1:0] in_data = 0, ram_wr_data, ram_rd_data, out_data;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [PW-1:0] num_passes = 0, out_pass;
  logic [BD-1:0] mem [0:(1<<AW)-1];
  logic [BD-1:0] pix [DEPTH];
  logic [BD-1:0] q_d[$];
  logic [PW-1:0] q_p[$];
  logic q_l[$];
  int checks = 0, passed = 0;
  int c_first_valid, c_first_hs, c_last_hs, c_done, n_stall_err, n_wr_err;
  bit done_in_ready, timed_out, ld_to;

  lutram_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .num_passes(num_passes), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .out_pass(out_pass), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr];

  // in_ready only changes at edges, so deciding at the negedge predicts the next edge's handshake
  task automatic load_frame(input int n, input int gap_pct);
    int i = 0;
    int g = 0;
    ld_to = 0;
    while (i < n && g < 50000) begin
      @(negedge clk);
      g++;
      in_valid = $urandom_range(99) >= gap_pct;
      in_data = pix[i];
      if (in_valid && in_ready) i++;
    end
    if (i < n) ld_to = 1;
  endtask

  task automatic collect(input int ready_pct, input bit drive_in, input int max_hs);
    int c = 0;
    int hs = 0;
    logic pv = 0, pr = 0, pl = 0;
    logic [BD-1:0] pd = 0;
    logic [PW-1:0] pp = 0;
    q_d.delete(); q_p.delete(); q_l.delete();
    c_first_valid = -1; c_first_hs = -1; c_last_hs = -1; c_done = -1;
    n_stall_err = 0; n_wr_err = 0; done_in_ready = 0; timed_out = 0;
    while (c < 20000) begin
      @(negedge clk);
      if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl || out_pass !== pp)) n_stall_err++;
      if (frame_done) begin
        c_done = c;
        done_in_ready = in_ready;
        in_valid = 0;
        break;
      end
      if (ram_wr_en) n_wr_err++;
      if (out_valid && c_first_valid < 0) c_first_valid = c;
      if (hs == max_hs) break;
      out_ready = $urandom_range(99) < ready_pct;
      in_valid = drive_in;
      in_data = 8'hAA;
      if (out_valid && out_ready) begin
        q_d.push_back(out_data); q_p.push_back(out_pass); q_l.push_back(out_last);
        hs++;
        if (c_first_hs < 0) c_first_hs = c;
        c_last_hs = c;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last; pp = out_pass;
      c++;
    end
    if (c >= 20000) timed_out = 1;
  endtask

  function automatic int stream_errs(output int bad);
    int e = 0;
    bad = -1;
    for (int k = 0; k < q_d.size(); k++) begin
      if (q_d[k] !== pix[k % DEPTH] || q_p[k] !== PW'(k / DEPTH) || q_l[k] !== ((k % DEPTH) == DEPTH - 1)) begin
        e++;
        if (bad < 0) bad = k;
      end
    end
    return e;
  endfunction

  function automatic int count_last();
    int n = 0;
    foreach (q_l[k]) if (q_l[k]) n++;
    return n;
  endfunction

  task automatic test_reset;
    rst_n = 0; in_valid = 0; out_ready = 0; num_passes = 0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    checks++; if (ram_wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", ram_wr_en); else passed++;
    checks++; if (ram_rd_addr !== '0) $display("FAIL reset_rd_addr got %0d want 0", ram_rd_addr); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last); else passed++;
    checks++; if (out_data !== '0) $display("FAIL reset_out_data got %0h want 0", out_data); else passed++;
    checks++; if (out_pass !== '0) $display("FAIL reset_out_pass got %0d want 0", out_pass); else passed++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else passed++;
    rst_n = 1;
  endtask

  task automatic test_single_pass;
    int bad, e;
    for (int i = 0; i < DEPTH; i++) pix[i] = 8'(i);
    num_passes = 1;
    load_frame(DEPTH, 0);
    collect(100, 0, BIG);
    e = stream_errs(bad);
    checks++; if (ld_to || timed_out) $display("FAIL single_timeout got load=%b stream=%b want 0", ld_to, timed_out); else passed++;
    checks++; if (q_d.size() !== DEPTH) $display("FAIL single_count got %0d want %0d", q_d.size(), DEPTH); else passed++;
    checks++; if (e !== 0) $display("FAIL single_data got %0d bad (first idx %0d) want 0", e, bad); else passed++;
    checks++; if (count_last() !== 1) $display("FAIL single_last got %0d want 1", count_last()); else passed++;
    checks++; if (c_first_valid !== 1) $display("FAIL single_latency got %0d want 1", c_first_valid); else passed++;
    checks++; if (c_last_hs - c_first_hs !== DEPTH - 1) $display("FAIL single_gapless got %0d want %0d", c_last_hs - c_first_hs, DEPTH - 1); else passed++;
    checks++; if (c_done !== c_last_hs + 1) $display("FAIL single_done_cycle got %0d want %0d", c_done, c_last_hs + 1); else passed++;
    checks++; if (done_in_ready !== 1'b1) $display("FAIL single_done_in_ready got %b want 1", done_in_ready); else passed++;
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) $display("FAIL single_done_pulse got %b want 0", frame_done); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL single_in_ready_after got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_multi_pass;
    int bad, e;
    for (int i = 0; i < DEPTH; i++) pix[i] = 8'(i * 7 + 3);
    num_passes = 3;
    load_frame(DEPTH, 0);
    collect(100, 0, BIG);
    e = stream_errs(bad);
    checks++; if (ld_to || timed_out) $display("FAIL multi_timeout got load=%b stream=%b want 0", ld_to, timed_out); else passed++;
    checks++; if (q_d.size() !== 3 * DEPTH) $display("FAIL multi_count got %0d want %0d", q_d.size(), 3 * DEPTH); else passed++;
    checks++; if (e !== 0) $display("FAIL multi_data got %0d bad (first idx %0d) want 0", e, bad); else passed++;
    checks++; if (count_last() !== 3) $display("FAIL multi_last got %0d want 3", count_last()); else passed++;
    checks++; if (c_last_hs - c_first_hs !== 3 * DEPTH - 1) $display("FAIL multi_gapless got %0d want %0d", c_last_hs - c_first_hs, 3 * DEPTH - 1); else passed++;
    checks++; if (c_done !== c_last_hs + 1) $display("FAIL multi_done_cycle got %0d want %0d", c_done, c_last_hs + 1); else passed++;
  endtask

  task automatic test_backpressure;
    int bad, e;
    for (int i = 0; i < DEPTH; i++) pix[i] = 8'($urandom);
    num_passes = 2;
    load_frame(DEPTH, 30);
    collect(50, 0, BIG);
    e = stream_errs(bad);
    checks++; if (ld_to || timed_out) $display("FAIL bp_timeout got load=%b stream=%b want 0", ld_to, timed_out); else passed++;
    checks++; if (q_d.size() !== 2 * DEPTH) $display("FAIL bp_count got %0d want %0d", q_d.size(), 2 * DEPTH); else passed++;
    checks++; if (e !== 0) $display("FAIL bp_data got %0d bad (first idx %0d) want 0", e, bad); else passed++;
    checks++; if (n_stall_err !== 0) $display("FAIL bp_stable got %0d unstable stalls want 0", n_stall_err); else passed++;
    checks++; if (c_done !== c_last_hs + 1) $display("FAIL bp_done_cycle got %0d want %0d", c_done, c_last_hs + 1); else passed++;
  endtask

  task automatic test_zero_passes;
    int bad, e;
    for (int i = 0; i < DEPTH; i++) pix[i] = 8'(255 - i);
    num_passes = 0;
    load_frame(DEPTH, 0);
    @(posedge clk);
    #1 num_passes = 5;
    collect(100, 0, BIG);
    e = stream_errs(bad);
    checks++; if (ld_to || timed_out) $display("FAIL zero_timeout got load=%b stream=%b want 0", ld_to, timed_out); else passed++;
    checks++; if (q_d.size() !== DEPTH) $display("FAIL zero_count got %0d want %0d", q_d.size(), DEPTH); else passed++;
    checks++; if (e !== 0) $display("FAIL zero_data got %0d bad (first idx %0d) want 0", e, bad); else passed++;
  endtask

  task automatic test_reset_mid;
    int bad, e;
    for (int i = 0; i < DEPTH; i++) pix[i] = 8'h5A ^ 8'(i);
    num_passes = 1;
    load_frame(400, 0);
    @(negedge clk);
    rst_n = 0; in_valid = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL rstload_in_ready got %b want 1", in_ready); else passed++;
    rst_n = 1;
    for (int i = 0; i < DEPTH; i++) pix[i] = 8'(i * 3);
    load_frame(DEPTH, 0);
    collect(100, 0, BIG);
    e = stream_errs(bad);
    checks++; if (ld_to || timed_out) $display("FAIL rstload_timeout got load=%b stream=%b want 0", ld_to, timed_out); else passed++;
    checks++; if (q_d.size() !== DEPTH) $display("FAIL rstload_count got %0d want %0d", q_d.size(), DEPTH); else passed++;
    checks++; if (e !== 0) $display("FAIL rstload_data got %0d bad (first idx %0d) want 0", e, bad); else passed++;
    num_passes = 2;
    load_frame(DEPTH, 0);
    collect(100, 0, DEPTH + 500);
    e = stream_errs(bad);
    checks++; if (q_d.size() !== DEPTH + 500) $display("FAIL rststream_count got %0d want %0d", q_d.size(), DEPTH + 500); else passed++;
    checks++; if (e !== 0) $display("FAIL rststream_data got %0d bad (first idx %0d) want 0", e, bad); else passed++;
    rst_n = 0; out_ready = 0; in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL rststream_out_valid got %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rststream_in_ready got %b want 1", in_ready); else passed++;
    checks++; if (ram_rd_addr !== '0) $display("FAIL rststream_rd_addr got %0d want 0", ram_rd_addr); else passed++;
    checks++; if (out_pass !== '0) $display("FAIL rststream_out_pass got %0d want 0", out_pass); else passed++;
    rst_n = 1;
  endtask

  task automatic test_ignored_input;
    int bad, e;
    for (int i = 0; i < DEPTH; i++) pix[i] = 8'(i) ^ 8'hC3;
    num_passes = 2;
    load_frame(DEPTH, 0);
    collect(100, 1, BIG);
    e = stream_errs(bad);
    checks++; if (ld_to || timed_out) $display("FAIL ignore_timeout got load=%b stream=%b want 0", ld_to, timed_out); else passed++;
    checks++; if (n_wr_err !== 0) $display("FAIL ignore_wr_en got %0d writes want 0", n_wr_err); else passed++;
    checks++; if (q_d.size() !== 2 * DEPTH) $display("FAIL ignore_count got %0d want %0d", q_d.size(), 2 * DEPTH); else passed++;
    checks++; if (e !== 0) $display("FAIL ignore_data got %0d bad (first idx %0d) want 0", e, bad); else passed++;
  endtask

  initial begin
    test_reset;
    test_single_pass;
    test_multi_pass;
    test_backpressure;
    test_zero_passes;
    test_reset_mid;
    test_ignored_input;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
